// File: rtl/serial_subtractor.sv
// Purpose: bit-serial N-bit unsigned subtractor (A - B), LSB first, one bit per clock.
// Latency: done pulses N+1 cycles after start is accepted; one operation per N+2 cycles.
// Backpressure: start is honoured only while ready=1; start during RUN/DONE is dropped, never queued.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic [N-1:0]   d_sh;
    logic           br;
    logic [CW-1:0]  cnt;

    logic           ai;
    logic           bi;
    logic           d_bit;
    logic           br_nxt;
    logic           last_bit;

    // One full-subtractor slice on the current LSBs plus the registered borrow.
    always_comb begin
        ai       = a_sh[0];
        bi       = b_sh[0];
        d_bit    = ai ^ bi ^ br;
        br_nxt   = (~ai & bi) | (~(ai ^ bi) & br);
        last_bit = (cnt == CW'(N - 1));
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, bit-serial shifting, and result publication on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        d_sh <= '0;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= {d_bit, d_sh[N-1:1]};
                    br   <= br_nxt;
                    if (last_bit) begin
                        // Visible outputs change only here, so they hold stable until the next result.
                        diff   <= {d_bit, d_sh[N-1:1]};
                        borrow <= br_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose: self-checking bench for serial_subtractor (N=8) against an arithmetic reference.
// Latency: checks done timing, ready-low window and back-to-back period.
// Backpressure: exercises start during RUN, held start, and reset mid-operation.
module tb_serial_subtractor;

    localparam int N   = 8;
    localparam int LAT = N + 1;   // cycles from accept to the done cycle
    localparam int PER = N + 2;   // accept-to-accept period with start held high

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;

    int tests;
    int fails;

    serial_subtractor #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic [N-1:0] exp_diff;
        logic         exp_borrow;
    } vec_t;

    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
    } op_t;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_diff(input logic [N-1:0] x, input logic [N-1:0] y);
        return N'((x + (1 << N) - y) % (1 << N));
    endfunction

    function automatic logic ref_borrow(input logic [N-1:0] x, input logic [N-1:0] y);
        return (x < y);
    endfunction

    // Start one operation and wait for done; returns cycle index of done and ready-low count.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          output int lat, output int rlow, output logic seen);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        rlow  = 0;
        seen  = 1'b0;
        while (lat < 40) begin
            if (!ready) rlow++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
            lat++;
        end
    endtask

    vec_t        vecs[5];
    op_t         pending[$];
    int          lat;
    int          rlow;
    logic        seen;
    logic [N-1:0] held;
    int          ndone;
    logic [N-1:0] cap_diff;
    logic        cap_borrow;
    int          completed;
    int          accepts;
    int          last_acc;
    int          cyc;
    int          bad_period;
    op_t         op;

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'h7F, 8'h7F, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_borrow", 32'(borrow), 32'd0);

        // Directed vectors: result, timing, and hold after completion.
        for (int i = 0; i < 5; i++) begin
            chk("vec_ready_before", 32'(ready), 32'd1);
            run_op(vecs[i].va, vecs[i].vb, lat, rlow, seen);
            chk("vec_done_seen", 32'(seen), 32'd1);
            chk("vec_latency", 32'(lat), 32'(LAT));
            chk("vec_ready_low", 32'(rlow), 32'(LAT));
            chk("vec_diff", 32'(diff), 32'(vecs[i].exp_diff));
            chk("vec_borrow", 32'(borrow), 32'(vecs[i].exp_borrow));
            held = diff;
            tick();
            chk("vec_done_pulse", 32'(done), 32'd0);
            chk("vec_ready_after", 32'(ready), 32'd1);
            tick();
            chk("vec_diff_hold", 32'(diff), 32'(held));
        end

        // start during RUN is dropped: one done only, with the first operands.
        a     = 8'h5A;
        b     = 8'h23;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = '0;
        b     = '0;
        ndone = 0;
        cap_diff   = '0;
        cap_borrow = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                ndone++;
                cap_diff   = diff;
                cap_borrow = borrow;
            end
            tick();
        end
        chk("ignore_done_count", 32'(ndone), 32'd1);
        chk("ignore_diff", 32'(cap_diff), 32'h37);
        chk("ignore_borrow", 32'(cap_borrow), 32'd0);

        // Reset in the 4th RUN cycle aborts with no done.
        a     = 8'h5A;
        b     = 8'h23;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(8'h10, 8'h20, lat, rlow, seen);
        chk("post_abort_seen", 32'(seen), 32'd1);
        chk("post_abort_diff", 32'(diff), 32'hF0);
        chk("post_abort_borrow", 32'(borrow), 32'd1);
        tick();

        // start held high with operands changing every cycle; 200 random operations.
        completed  = 0;
        accepts    = 0;
        last_acc   = 0;
        bad_period = 0;
        cyc        = 0;
        start      = 1'b1;
        while (completed < 200 && cyc < 200 * PER + 100) begin
            if (done) begin
                if (pending.size() == 0) begin
                    chk("b2b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    op = pending.pop_front();
                    chk("b2b_diff", 32'(diff), 32'(ref_diff(op.va, op.vb)));
                    chk("b2b_borrow", 32'(borrow), 32'(ref_borrow(op.va, op.vb)));
                end
                completed++;
            end
            a = N'($urandom);
            b = N'($urandom);
            if (ready && accepts < 200) begin
                if (accepts > 0 && (cyc - last_acc) != PER) bad_period++;
                last_acc = cyc;
                accepts++;
                pending.push_back('{a, b});
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("b2b_completed", 32'(completed), 32'd200);
        chk("b2b_period_errors", 32'(bad_period), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
